// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- buffered 8N1/8N2 UART transmitter.
//
// A producer pushes bytes through a valid/ready handshake into a small FIFO.
// A four-state FSM pops them one at a time and serialises each one on `tx`,
// LSB first, at CLK_FREQ/BAUD clock cycles per bit. Queued bytes follow each
// other with no idle gap: the next start bit begins on the same edge that
// ends the previous stop bit.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   BAUD       line rate; bit period DIV = CLK_FREQ/BAUD (truncated), DIV >= 1
//   FIFO_DEPTH FIFO entries, power of two, >= 2
//   STOP_BITS  1 or 2
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   tx_data     byte to send
//   tx_valid    tx_data is valid this cycle
//   tx_ready    FIFO not full; a byte is taken when tx_valid && tx_ready
//   tx          registered serial line, idles high
//   busy        a frame is on the line (FSM not idle)
//   tx_done     one-cycle pulse after the last stop-bit cycle of each frame
//   fifo_count  bytes queued, excluding the byte being shifted out
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and control
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Transmit FSM state
  state_t        state;
  state_t        state_n;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shifter;
  logic [7:0]    shifter_n;
  logic          tx_r;
  logic          tx_n;
  logic          done_r;
  logic          done_n;
  logic          baud_last;
  logic          fifo_has_data;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never lets a byte into a full FIFO.
  assign tx_ready      = (count != FULL_CNT);
  assign push          = tx_valid && tx_ready;
  assign fifo_has_data = (count != '0);
  assign baud_last     = (baud_cnt == BAUD_LAST);

  // ---- FIFO write port (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // ---- FIFO pointers and occupancy ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide over a power-of-two depth, so they wrap
      // naturally.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- FSM next-state and line level ----
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shifter_n  = shifter;
    tx_n       = tx_r;
    done_n     = 1'b0;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        if (fifo_has_data) begin
          pop        = 1'b1;
          shifter_n  = mem[rd_ptr];
          tx_n       = 1'b0;
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = START;
        end
      end

      START: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          tx_n       = shifter[0];
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n      = 1'b1;
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shifter[bit_idx + 3'd1];
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        // bit_idx counts stop bits here, so 8N2 reuses the same counter.
        if (baud_last) begin
          baud_cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            done_n    = 1'b1;
            bit_idx_n = '0;
            if (fifo_has_data) begin
              // Back-to-back frame: start bit begins on this same edge.
              pop       = 1'b1;
              shifter_n = mem[rd_ptr];
              tx_n      = 1'b0;
              state_n   = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // ---- FSM control registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_r     <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      tx_r     <= tx_n;
      done_r   <= done_n;
    end
  end

  // ---- shift register (data only, no reset) ----
  always_ff @(posedge clk) begin
    shifter <= shifter_n;
  end

  assign tx         = tx_r;
  assign busy       = (state != IDLE);
  assign tx_done    = done_r;
  assign fifo_count = count;

endmodule
